tile_miss_issue_arb: RTL and testbench
======================================

# tile_miss_issue_arb

Miss-issue scheduler for one tile's XY mesh port. Accepts up to three cache-miss requests per cycle from the tile's miss ports, buffers them in order in an 8-entry queue, and issues one per cycle to the ring toward the home tile, either forward or backward, or to the local port. Issue is gated by per-direction link credits. Sits between the tile's miss ports and the ring-side injection queues of the cluster FIFO.

## Interface
- TILE_X, 0: this tile's X coordinate (2 bits used)
- TILE_Y, 0: this tile's Y coordinate (2 bits used)
- IDX, 0: ring index; 0-1 is the X ring and routes on addr[1:0], 2-3 is the Y ring and routes on addr[3:2]
- DEPTH, 8: queue entries (power of two, at least 4)
- CREDITS, 4: initial credits per ring direction

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_en  in  3  per-port miss request valid
- req_addr  in  3x39  miss line address per port
- req_phy  in  3x12  physical tag bits per port
- req_ready  out  1  queue can absorb 3 more entries (count <= DEPTH-3)
- flush  in  1  discard all queued entries
- out_vld  out  2  registered issue strobe; bit0 = back, bit1 = fwd
- out_addr  out  39  issued address
- out_phy  out  12  issued phy bits
- credit_ret  in  2  one credit returned per direction (bit0 back, bit1 fwd)
- local_vld  out  1  registered issue to the local home port
- local_ready  in  1  local port can accept
- overflow  out  1  sticky: a push was dropped, or a credit was returned while that direction was already full

## Operation
- Push: enabled ports are written in port order (0, 1, 2) into consecutive slots starting at wr_ptr. wr_ptr advances by popcount(req_en).
- If a push finds the queue full, that port's entry and all later ones are dropped, and overflow is set.
- Routing of the head entry:
  - d = IDX<2 ? addr[1:0] : addr[3:2]; o = IDX<2 ? TILE_X : TILE_Y.
  - d==o goes local; d>o goes fwd; d<o goes back.
- Pop: the head is issued when its target can accept: credit[dir] > 0 for a ring direction, local_ready for local.
- Ordering is strictly in order. A blocked head stalls every entry behind it.
- On issue, out_vld[dir] or local_vld is set for exactly one cycle with the head's addr and phy, and rd_ptr advances by 1.
- Credits:
  - credit[dir] decrements on issue to dir and increments on credit_ret[dir].
  - Issue and return in the same cycle leave the counter unchanged.
  - A return while the counter is at CREDITS is ignored and sets overflow.
- flush: count, wr_ptr and rd_ptr are cleared at the next edge. Pushes in the flush cycle are discarded. Credits are not affected. An issue decided in the flush cycle is suppressed.
- Count arithmetic: count_next = count + pushes - pop, using a 4-bit count. Pointers wrap modulo DEPTH.

## Timing
- A request at cycle N is stored at the end of N. If it is the head and its target can accept, the issue strobe is high in cycle N+2. Minimum latency is 2.
- Sustained throughput is one issue per cycle. Push and pop can occur in the same cycle, including when the queue is full (count==DEPTH): the pop frees a slot for push port 0.
- req_ready is a combinational decode of the registered count. Requesters must sample it before asserting req_en.
- Reset values:
  - out_vld=0, local_vld=0, out_addr=0, out_phy=0, overflow=0, req_ready=1
  - count, wr_ptr and rd_ptr = 0; both credits = CREDITS
- Reset asserted mid-operation drops all queued entries, and the strobes are low on the following cycle.
- Empty queue: no strobe. credit=0: the head waits, and the strobe appears one cycle after the credit_ret that releases it.

## Structure
- Shared package tile_mesh_pkg:
  - miss entry struct {addr[38:0], phy[11:0]}
  - direction enum {DIR_BACK, DIR_FWD, DIR_LOCAL}
  - coordinate field positions (X=addr[1:0], Y=addr[3:2])
- Sub-module tile_mreq_compact: turns req_en[2:0] into per-port write offsets (0..2) and a push count, with the full-queue truncation mask.
- The top level holds the queue storage, pointers, credit counters and output registers.

## Test plan
- IDX=0, TILE_X=1: push addr[1:0]=2 on port 0 at cycle 0 -> out_vld=2'b10 at cycle 2 with the same addr and phy; fwd credit becomes 3.
- req_en=3'b111 with addresses routing to 0, 1 and 3 on an idle queue -> back at cycle 2, local at cycle 3, fwd at cycle 4, in port order.
- 5 fwd requests with no credit_ret -> 4 issue; the 5th waits; credit_ret=2'b10 -> it issues the next cycle.
- Fill to 8 with back credit=0, then push 1 more -> the entry is dropped, overflow=1, req_ready=0.
- Hold local_ready=0 with the head routed local and 3 queued -> no strobes. Assert flush -> count 0, credits unchanged.
- Return credit_ret[0] while back credit=4 -> counter stays 4 and overflow=1. Assert rst at any point -> all outputs at reset values.

Source files
------------

// File: rtl/tile_mesh_pkg.sv
// Shared types for the tile mesh miss path: miss entry layout, ring directions
// and the routing decision for the entry at the head of the queue.
package tile_mesh_pkg;

    localparam int ADDR_W  = 39;
    localparam int PHY_W   = 12;
    localparam int X_LSB   = 0;
    localparam int Y_LSB   = 2;
    localparam int NPORT   = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PHY_W-1:0]  phy;
    } miss_entry_t;

    typedef enum logic [1:0] {
        DIR_BACK  = 2'd0,
        DIR_FWD   = 2'd1,
        DIR_LOCAL = 2'd2
    } dir_e;

    // X rings (idx 0-1) compare addr[1:0], Y rings (idx 2-3) compare addr[3:2]
    function automatic dir_e routeDir(input logic [3:0] coord, input int idx, input logic [1:0] own);
        logic [1:0] d;
        d = (idx < 2) ? coord[X_LSB +: 2] : coord[Y_LSB +: 2];
        if (d == own)
            return DIR_LOCAL;
        else if (d > own)
            return DIR_FWD;
        else
            return DIR_BACK;
    endfunction

endpackage

// File: rtl/tile_mreq_compact.sv
// Packs the enabled miss ports into consecutive queue slots and drops every
// port that would land past the available space.
module tile_mreq_compact #(
    parameter int CW = 4
) (
    input  logic [2:0]      i_reqEn,
    input  logic [CW-1:0]   i_space,
    input  logic            i_flush,
    output logic [2:0][1:0] o_off,
    output logic [2:0]      o_keep,
    output logic [1:0]      o_pushCnt,
    output logic            o_drop
);

    // Offsets count only enabled lower ports, so truncation at the first
    // port that does not fit also removes all later enabled ports.
    always_comb begin
        o_off[0] = 2'd0;
        o_off[1] = {1'b0, i_reqEn[0]};
        o_off[2] = {1'b0, i_reqEn[0]} + {1'b0, i_reqEn[1]};
        o_keep   = 3'b000;
        for (int k = 0; k < 3; k++) begin
            o_keep[k] = i_reqEn[k] && !i_flush && (CW'(o_off[k]) < i_space);
        end
        o_pushCnt = 2'(o_keep[0]) + 2'(o_keep[1]) + 2'(o_keep[2]);
        o_drop    = !i_flush && |(i_reqEn & ~o_keep);
    end

endmodule

// File: rtl/tile_miss_issue_arb.sv
// In-order miss-issue scheduler: queues up to three misses per cycle and issues
// the head toward its home tile (back, fwd or local), gated by link credits.
module tile_miss_issue_arb
    import tile_mesh_pkg::*;
#(
    parameter int TILE_X  = 0,
    parameter int TILE_Y  = 0,
    parameter int IDX     = 0,
    parameter int DEPTH   = 8,
    parameter int CREDITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              i_reqEn,
    input  logic [2:0][ADDR_W-1:0]  i_reqAddr,
    input  logic [2:0][PHY_W-1:0]   i_reqPhy,
    output logic                    o_reqReady,
    input  logic                    i_flush,
    output logic [1:0]              o_outVld,
    output logic [ADDR_W-1:0]       o_outAddr,
    output logic [PHY_W-1:0]        o_outPhy,
    input  logic [1:0]              i_creditRet,
    output logic                    o_localVld,
    input  logic                    i_localReady,
    output logic                    o_overflow
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int CRW = $clog2(CREDITS + 1);

    miss_entry_t     r_mem [DEPTH];
    logic [PW-1:0]   r_wrPtr;
    logic [PW-1:0]   r_rdPtr;
    logic [CW-1:0]   r_count;
    logic [CRW-1:0]  r_credBack;
    logic [CRW-1:0]  r_credFwd;
    logic [1:0]      r_outVld;
    logic            r_localVld;
    logic [ADDR_W-1:0] r_outAddr;
    logic [PHY_W-1:0]  r_outPhy;
    logic            r_overflow;

    miss_entry_t     w_head;
    logic [1:0]      w_own;
    dir_e            w_dir;
    logic            w_pop;
    logic [CW-1:0]   w_space;
    logic [2:0][1:0] w_off;
    logic [2:0]      w_keep;
    logic [1:0]      w_pushCnt;
    logic            w_drop;
    logic [CRW-1:0]  w_credBackNext;
    logic [CRW-1:0]  w_credFwdNext;
    logic            w_credOvf;

    assign w_head     = r_mem[r_rdPtr];
    assign w_own      = (IDX < 2) ? TILE_X[1:0] : TILE_Y[1:0];
    assign w_dir      = routeDir(w_head.addr[3:0], IDX, w_own);
    assign o_reqReady = (r_count <= CW'(DEPTH - 3));
    assign w_space    = CW'(DEPTH) - r_count + CW'(w_pop);

    // A credit returned this cycle can release the head immediately.
    always_comb begin
        w_pop = 1'b0;
        if (r_count != '0 && !i_flush) begin
            case (w_dir)
                DIR_BACK:  w_pop = (r_credBack != '0) || i_creditRet[0];
                DIR_FWD:   w_pop = (r_credFwd  != '0) || i_creditRet[1];
                DIR_LOCAL: w_pop = i_localReady;
                default:   w_pop = 1'b0;
            endcase
        end
    end

    tile_mreq_compact #(.CW(CW)) u_compact (
        .i_reqEn   (i_reqEn),
        .i_space   (w_space),
        .i_flush   (i_flush),
        .o_off     (w_off),
        .o_keep    (w_keep),
        .o_pushCnt (w_pushCnt),
        .o_drop    (w_drop)
    );

    // A return to a full counter is ignored but still lets a same-cycle issue decrement.
    always_comb begin
        logic takeB, takeF, giveB, giveF;
        takeB = w_pop && (w_dir == DIR_BACK);
        takeF = w_pop && (w_dir == DIR_FWD);
        giveB = i_creditRet[0] && (r_credBack != CRW'(CREDITS));
        giveF = i_creditRet[1] && (r_credFwd  != CRW'(CREDITS));
        w_credOvf = (i_creditRet[0] && (r_credBack == CRW'(CREDITS)))
                 || (i_creditRet[1] && (r_credFwd  == CRW'(CREDITS)));
        w_credBackNext = r_credBack;
        w_credFwdNext  = r_credFwd;
        if (takeB && !giveB)      w_credBackNext = r_credBack - 1'b1;
        else if (giveB && !takeB) w_credBackNext = r_credBack + 1'b1;
        if (takeF && !giveF)      w_credFwdNext = r_credFwd - 1'b1;
        else if (giveF && !takeF) w_credFwdNext = r_credFwd + 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (w_keep[k]) begin
                r_mem[r_wrPtr + PW'(w_off[k])] <= '{addr: i_reqAddr[k], phy: i_reqPhy[k]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_credBack <= CRW'(CREDITS);
            r_credFwd  <= CRW'(CREDITS);
            r_outVld   <= 2'b00;
            r_localVld <= 1'b0;
            r_outAddr  <= '0;
            r_outPhy   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_credBack <= w_credBackNext;
            r_credFwd  <= w_credFwdNext;
            r_overflow <= r_overflow | w_drop | w_credOvf;
            r_outVld   <= {w_pop && (w_dir == DIR_FWD), w_pop && (w_dir == DIR_BACK)};
            r_localVld <= w_pop && (w_dir == DIR_LOCAL);
            if (w_pop) begin
                r_outAddr <= w_head.addr;
                r_outPhy  <= w_head.phy;
            end
            if (i_flush) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
                r_count <= '0;
            end else begin
                r_wrPtr <= r_wrPtr + PW'(w_pushCnt);
                r_rdPtr <= r_rdPtr + PW'(w_pop);
                r_count <= r_count + CW'(w_pushCnt) - CW'(w_pop);
            end
        end
    end

    assign o_outVld   = r_outVld;
    assign o_localVld = r_localVld;
    assign o_outAddr  = r_outAddr;
    assign o_outPhy   = r_outPhy;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_tile_miss_issue_arb.sv
// Directed bench for tile_miss_issue_arb on an X ring (IDX=0) at TILE_X=1,
// so addr[1:0]=0 routes back, 1 local, 2 and 3 fwd.
module tb_tile_miss_issue_arb;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       reqEn;
    logic [2:0][38:0] reqAddr;
    logic [2:0][11:0] reqPhy;
    logic             reqReady;
    logic             flush;
    logic [1:0]       outVld;
    logic [38:0]      outAddr;
    logic [11:0]      outPhy;
    logic [1:0]       creditRet;
    logic             localVld;
    logic             localReady;
    logic             overflow;

    int compared   = 0;
    int mismatched = 0;
    int nBack, nFwd, nLocal;
    logic [38:0] lastAddr;

    tile_miss_issue_arb #(
        .TILE_X(1), .TILE_Y(0), .IDX(0), .DEPTH(8), .CREDITS(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_reqEn      (reqEn),
        .i_reqAddr    (reqAddr),
        .i_reqPhy     (reqPhy),
        .o_reqReady   (reqReady),
        .i_flush      (flush),
        .o_outVld     (outVld),
        .o_outAddr    (outAddr),
        .o_outPhy     (outPhy),
        .i_creditRet  (creditRet),
        .o_localVld   (localVld),
        .i_localReady (localReady),
        .o_overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [38:0] mkAddr(input logic [7:0] tag, input int port, input logic [1:0] d);
        return {23'd0, tag, 4'(port), 2'b00, d};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] en, input logic [1:0] d0, input logic [1:0] d1,
                                 input logic [1:0] d2, input logic [7:0] tag);
        reqEn      = en;
        reqAddr[0] = mkAddr(tag, 0, d0);
        reqAddr[1] = mkAddr(tag, 1, d1);
        reqAddr[2] = mkAddr(tag, 2, d2);
        for (int k = 0; k < 3; k++) reqPhy[k] = {4'h0, tag};
    endtask

    task automatic clearReq();
        reqEn = 3'b000;
    endtask

    task automatic resetTally();
        nBack = 0; nFwd = 0; nLocal = 0; lastAddr = '0;
    endtask

    task automatic tally();
        if (outVld[0]) nBack++;
        if (outVld[1]) nFwd++;
        if (localVld) nLocal++;
        if (outVld != 2'b00 || localVld) lastAddr = outAddr;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            tally();
        end
    endtask

    task automatic doReset();
        rst = 1'b1; clearReq(); flush = 1'b0; creditRet = 2'b00; localReady = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " outVld"},   64'(outVld),   64'h0);
        checkOutput({tag, " localVld"}, 64'(localVld), 64'h0);
        checkOutput({tag, " outAddr"},  64'(outAddr),  64'h0);
        checkOutput({tag, " outPhy"},   64'(outPhy),   64'h0);
        checkOutput({tag, " overflow"}, 64'(overflow), 64'h0);
        checkOutput({tag, " reqReady"}, 64'(reqReady), 64'h1);
    endtask

    initial begin
        rst = 1'b1; reqEn = '0; reqAddr = '0; reqPhy = '0;
        flush = 1'b0; creditRet = 2'b00; localReady = 1'b1;
        step();
        step();
        rst = 1'b0;
        checkReset("reset");

        // single fwd miss: strobe two cycles after the request
        applyStimulus(3'b001, 2'd2, 2'd0, 2'd0, 8'h11);
        step();
        clearReq();
        checkOutput("s1 not early", 64'(outVld), 64'h0);
        step();
        checkOutput("s1 outVld", 64'(outVld), 64'h2);
        checkOutput("s1 outAddr", 64'(outAddr), 64'(mkAddr(8'h11, 0, 2'd2)));
        checkOutput("s1 outPhy", 64'(outPhy), 64'h011);
        checkOutput("s1 localVld", 64'(localVld), 64'h0);
        step();
        checkOutput("s1 one-shot", 64'(outVld), 64'h0);

        // three ports in one cycle issue in port order: back, local, fwd
        applyStimulus(3'b111, 2'd0, 2'd1, 2'd3, 8'h20);
        step();
        clearReq();
        step();
        checkOutput("s2 back vld", 64'(outVld), 64'h1);
        checkOutput("s2 back addr", 64'(outAddr), 64'(mkAddr(8'h20, 0, 2'd0)));
        step();
        checkOutput("s2 local vld", 64'({outVld, localVld}), 64'h1);
        checkOutput("s2 local addr", 64'(outAddr), 64'(mkAddr(8'h20, 1, 2'd1)));
        step();
        checkOutput("s2 fwd vld", 64'({outVld, localVld}), 64'h4);
        checkOutput("s2 fwd addr", 64'(outAddr), 64'(mkAddr(8'h20, 2, 2'd3)));

        doReset();
        checkReset("rst mid");

        // five fwd misses against four credits
        resetTally();
        applyStimulus(3'b111, 2'd2, 2'd2, 2'd2, 8'h30);
        step();
        applyStimulus(3'b011, 2'd2, 2'd3, 2'd2, 8'h31);
        step();
        clearReq();
        tally();
        runCycles(8);
        checkOutput("s3 fwd issued", 64'(nFwd), 64'd4);
        checkOutput("s3 others", 64'(nBack + nLocal), 64'd0);
        creditRet = 2'b10;
        step();
        creditRet = 2'b00;
        checkOutput("s3 release vld", 64'(outVld), 64'h2);
        checkOutput("s3 release addr", 64'(outAddr), 64'(mkAddr(8'h31, 1, 2'd3)));
        step();
        checkOutput("s3 after release", 64'(outVld), 64'h0);

        doReset();

        // drain back credits, then fill the queue to 8 and overflow it
        resetTally();
        applyStimulus(3'b111, 2'd0, 2'd0, 2'd0, 8'h40);
        step();
        applyStimulus(3'b001, 2'd0, 2'd0, 2'd0, 8'h41);
        step();
        clearReq();
        tally();
        runCycles(8);
        checkOutput("s4 back drained", 64'(nBack), 64'd4);
        applyStimulus(3'b111, 2'd0, 2'd0, 2'd0, 8'h50);
        step();
        checkOutput("s4 ready at 3", 64'(reqReady), 64'h1);
        applyStimulus(3'b111, 2'd0, 2'd0, 2'd0, 8'h51);
        step();
        checkOutput("s4 ready at 6", 64'(reqReady), 64'h0);
        applyStimulus(3'b011, 2'd0, 2'd0, 2'd0, 8'h52);
        step();
        checkOutput("s4 no overflow yet", 64'(overflow), 64'h0);
        applyStimulus(3'b001, 2'd0, 2'd0, 2'd0, 8'h53);
        step();
        clearReq();
        checkOutput("s4 overflow", 64'(overflow), 64'h1);
        checkOutput("s4 ready full", 64'(reqReady), 64'h0);
        checkOutput("s4 stalled", 64'(outVld), 64'h0);
        // full queue: a pop in the same cycle makes room for port 0
        resetTally();
        applyStimulus(3'b001, 2'd0, 2'd0, 2'd0, 8'h54);
        creditRet = 2'b01;
        step();
        clearReq();
        tally();
        checkOutput("s4 head addr", 64'(outAddr), 64'(mkAddr(8'h50, 0, 2'd0)));
        runCycles(11);
        creditRet = 2'b00;
        checkOutput("s4 back total", 64'(nBack), 64'd9);
        checkOutput("s4 last addr", 64'(lastAddr), 64'(mkAddr(8'h54, 0, 2'd0)));

        doReset();

        // local head blocked, then flushed together with a same-cycle push
        resetTally();
        localReady = 1'b0;
        applyStimulus(3'b111, 2'd1, 2'd1, 2'd1, 8'h60);
        step();
        clearReq();
        runCycles(5);
        checkOutput("s5 blocked", 64'(nBack + nFwd + nLocal), 64'd0);
        flush = 1'b1;
        localReady = 1'b1;
        applyStimulus(3'b001, 2'd1, 2'd1, 2'd1, 8'h61);
        step();
        flush = 1'b0;
        clearReq();
        checkOutput("s5 flush suppress", 64'(localVld), 64'h0);
        checkOutput("s5 ready after flush", 64'(reqReady), 64'h1);
        runCycles(4);
        checkOutput("s5 empty after flush", 64'(nLocal), 64'd0);
        resetTally();
        applyStimulus(3'b111, 2'd2, 2'd2, 2'd2, 8'h62);
        step();
        applyStimulus(3'b011, 2'd2, 2'd2, 2'd2, 8'h63);
        step();
        clearReq();
        tally();
        runCycles(8);
        checkOutput("s5 credits kept", 64'(nFwd), 64'd4);

        doReset();

        // credit return into a full counter
        creditRet = 2'b01;
        step();
        creditRet = 2'b00;
        checkOutput("s6 credit overflow", 64'(overflow), 64'h1);
        checkOutput("s6 no strobe", 64'(outVld), 64'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkReset("final rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
